// File: rtl/seg7_rx_decoder.sv
// seg7_rx_decoder: reads an active-low 7-segment bus back into hex digits.
// Patterns that hold for STABLE_CYCLES samples are accepted. Accepted
// patterns that are not blank are queued as {invalid, digit} in a
// first-word-fall-through FIFO, which has a valid/ready output.
// Build option: define SEG7_RX_SYNC_EN to add a 2-flop input synchronizer
// for asynchronous segment sources. This adds 2 cycles of latency.
//
// Output handshake: an entry is presented while out_valid=1. The entry is
// transferred and popped on a rising edge where out_valid & out_ready. The
// producer (this block) holds digit_out/invalid_out stable until that edge.
module seg7_rx_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [0:6]                    HEX_IN,
  output logic [3:0]                    digit_out,
  output logic                          invalid_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic                          dbg_state
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [6:0]  BLANK    = 7'b1111111;
  localparam logic [7:0]  CNT_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic {S_IDLE = 1'b0, S_QUAL = 1'b1} state_t;

  // Pattern written left to right as segment a..g maps onto bits [6:0].
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b1100000: decode = 5'h0B;
      7'b0110001: decode = 5'h0C;
      7'b1000010: decode = 5'h0D;
      7'b0110000: decode = 5'h0E;
      7'b0111000: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  logic [6:0] hex_w;
  logic [6:0] sample;
  assign hex_w = HEX_IN;

`ifdef SEG7_RX_SYNC_EN
  logic [6:0] sync1_q, sync2_q;
  // Two-flop synchronizer. It resets to blank so that the FSM idles after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= BLANK;
      sync2_q <= BLANK;
    end else begin
      sync1_q <= hex_w;
      sync2_q <= sync1_q;
    end
  end
  assign sample = sync2_q;
`else
  assign sample = hex_w;
`endif

  state_t     state_q, state_d;
  logic [6:0] last_q, last_d;
  logic [6:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic       push;

  // Stability qualification: next-state logic and the accept/push decision.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sample != last_q) begin
          cand_d  = sample;
          cnt_d   = 8'd1;
          state_d = S_QUAL;
        end
      end
      S_QUAL: begin
        if (sample == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            last_d  = cand_q;
            push    = (cand_q != BLANK);
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (sample == last_q) begin
          state_d = S_IDLE;
        end else begin
          cand_d = sample;
          cnt_d  = 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Qualification state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= BLANK;
      cand_q  <= BLANK;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

  logic [4:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic        ovf_q;
  logic        full, pop, push_ok, ovf_set;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  // FIFO storage. Only the head is observed, and it is gated by out_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= decode(cand_q);
  end

  // FIFO pointers, occupancy and sticky overflow. A new set wins over clr_ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign out_valid   = (count_q != '0);
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;
  assign digit_out   = out_valid ? mem_q[rd_q][3:0] : 4'h0;
  assign invalid_out = out_valid & mem_q[rd_q][4];

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Testbench for seg7_rx_decoder. It runs directed scenarios and random bus
// traffic against a reference model. The model is run-length based and
// tracks the FIFO in a queue.
module tb_seg7_rx_decoder;

  localparam int SC = 4;
  localparam int FD = 4;
  localparam int CW = $clog2(FD) + 1;
`ifdef SEG7_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam logic [6:0] BLANK = 7'b1111111;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:6]    hex;
  logic [3:0]    digit_out;
  logic          invalid_out, out_valid, out_ready, overflow, clr_ovf, dbg_state;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  seg7_rx_decoder #(.STABLE_CYCLES(SC), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .HEX_IN(hex), .digit_out(digit_out),
    .invalid_out(invalid_out), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overflow(overflow), .clr_ovf(clr_ovf),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic [4:0] exp_q [$];   // expected FIFO contents {invalid, digit}
  logic [6:0] hist  [$];   // most recent SC samples seen by the decoder
  logic [6:0] pipe  [$];   // synchronizer delay line
  logic [6:0] m_last;
  logic       m_ovf;
  int         pops, pushes;

  function automatic logic [4:0] m_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (tbl[i] == p) return {1'b0, 4'(i)};
    return 5'b10000;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    pipe.delete();
    for (int i = 0; i < SYNC; i++) pipe.push_back(BLANK);
    m_last = BLANK;
    m_ovf  = 1'b0;
  endtask

  // Advance the model by one rising edge, then let the DUT take the edge and compare.
  task automatic tick();
    logic [6:0] s;
    logic [6:0] h;
    bit acc, pop, push;
    h = hex;
    if (SYNC == 0) s = h;
    else begin
      s = pipe.pop_front();
      pipe.push_back(h);
    end
    hist.push_back(s);
    if (hist.size() > SC) void'(hist.pop_front());
    acc = (hist.size() == SC) && (s != m_last);
    foreach (hist[i]) if (hist[i] != s) acc = 0;
    if (acc) m_last = s;
    push = acc && (s != BLANK);
    pop  = (exp_q.size() != 0) && out_ready;
    if (pop) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (push) begin
      pushes++;
      if (exp_q.size() == FD) m_ovf = 1'b1;
      else exp_q.push_back(m_decode(s));
    end
    if (!(push && exp_q.size() == FD && !pop) && clr_ovf && !(push && m_ovf && !pop && exp_q.size() == FD))
      ;
    @(posedge clk);
    @(negedge clk);
    check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check_eq("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      check_eq("digit_out", 32'(digit_out), 32'(exp_q[0][3:0]));
      check_eq("invalid_out", 32'(invalid_out), 32'(exp_q[0][4]));
    end else begin
      check_eq("digit_out_empty", 32'(digit_out), 32'd0);
      check_eq("invalid_out_empty", 32'(invalid_out), 32'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Overflow model step: the set takes priority over the clear. This is evaluated before each edge.
  bit ovf_set_pending;

  task automatic cycle();
    bit full_push;
    full_push = 0;
    // Predict whether this edge sets overflow, using the same run-length view.
    begin
      logic [6:0] s;
      logic [6:0] tmp [$];
      bit acc;
      s = (SYNC == 0) ? 7'(hex) : pipe[0];
      tmp = hist;
      tmp.push_back(s);
      if (tmp.size() > SC) void'(tmp.pop_front());
      acc = (tmp.size() == SC) && (s != m_last);
      foreach (tmp[i]) if (tmp[i] != s) acc = 0;
      full_push = acc && (s != BLANK) && (exp_q.size() == FD) && !out_ready;
    end
    if (!full_push && clr_ovf) m_ovf = 1'b0;
    tick();
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    hex = p;
    repeat (n) cycle();
  endtask

  // ---------------- stimulus ----------------
  int p0, n;

  initial begin
    rst_n     = 1'b0;
    hex       = BLANK;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    pops      = 0;
    pushes    = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_fifo_count", 32'(fifo_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_digit", 32'(digit_out), 32'd0);
    check_eq("rst_invalid", 32'(invalid_out), 32'd0);
    rst_n = 1'b1;

    // Full sweep: every table pattern in order, with the consumer always ready.
    out_ready = 1'b1;
    pops = 0;
    p0 = pushes;
    for (int i = 0; i < 16; i++) hold(tbl[i], 8);
    hold(tbl[15], 2);
    check_eq("sweep_pushes", 32'(pushes - p0), 32'd16);
    check_eq("sweep_pops", 32'(pops), 32'd16);

    // Glitch rejection: a short excursion away from an accepted "3" is discarded.
    hold(tbl[3], 10);
    p0 = pushes;
    hold(tbl[1], 2);
    hold(tbl[3], 10);
    check_eq("glitch_no_push", 32'(pushes - p0), 32'd0);

    // Repeat suppression: a held digit pushes once; blank lets it be sent again.
    p0 = pushes;
    hold(tbl[5], 20);
    check_eq("repeat_once", 32'(pushes - p0), 32'd1);
    hold(BLANK, 8);
    hold(tbl[5], 8);
    check_eq("repeat_after_blank", 32'(pushes - p0), 32'd2);

    // Invalid pattern produces a flagged entry with a zero digit.
    out_ready = 1'b0;
    hold(7'b1111110, 6 + SYNC);
    check_eq("invalid_flag", 32'(invalid_out), 32'd1);
    check_eq("invalid_digit", 32'(digit_out), 32'd0);
    out_ready = 1'b1;
    hold(7'b1111110, 2);

    // Overflow: five distinct digits with no consumer; the fifth is lost.
    out_ready = 1'b0;
    hold(tbl[1], 8);
    hold(tbl[2], 8);
    hold(tbl[3], 8);
    hold(tbl[4], 8);
    hold(tbl[6], 8);
    check_eq("ovf_count", 32'(fifo_count), 32'(FD));
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_head", 32'(digit_out), 32'd1);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    hold(tbl[6], 8);

    // Reset mid-operation: two entries queued and a pattern half qualified.
    out_ready = 1'b0;
    hold(BLANK, 8);
    hold(tbl[7], 8);
    hold(tbl[8], 8);
    check_eq("pre_rst_count", 32'(fifo_count), 32'd2);
    hex = tbl[9];
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_valid", 32'(out_valid), 32'd0);
    check_eq("async_rst_count", 32'(fifo_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      cycle();
      n++;
    end
    check_eq("rst_requal_latency", 32'(n), 32'(SC + SYNC));
    check_eq("rst_requal_digit", 32'(digit_out), 32'd9);

    // Random traffic: table digits, blanks, arbitrary patterns, random hold times and back-pressure.
    for (int k = 0; k < 250; k++) begin
      int r;
      logic [6:0] p;
      r = $urandom_range(0, 19);
      if (r < 16) p = tbl[r];
      else if (r < 18) p = BLANK;
      else p = 7'($urandom_range(0, 127));
      hex = p;
      repeat ($urandom_range(1, 10)) begin
        out_ready = 1'($urandom_range(0, 1));
        clr_ovf   = ($urandom_range(0, 15) == 0);
        cycle();
      end
    end
    clr_ovf = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
